// File: rtl/ni_inject_arbiter_pkg.sv
// Shared types for the NI injection path.
// Contents: arbiter FSM state enum, default flit width, and the head-flit
// field layout shared with the NI packetizers.
package ni_pkg;

    localparam int NI_FLIT_W = 32;

    typedef enum logic {
        NI_ARB_IDLE = 1'b0,
        NI_ARB_BUSY = 1'b1
    } ni_arb_state_t;

    // Head-flit layout produced by the packetizers (32-bit flits).
    typedef struct packed {
        logic [3:0]  dest;
        logic [3:0]  src;
        logic [7:0]  len;
        logic [15:0] rsvd;
    } ni_head_flit_t;

endpackage

// File: rtl/ni_inject_arbiter_if.sv
// Requester-side bundle of the NI injection arbiter.
// Signals: req_valid/req_last/req_ready (one bit per requester) and
// req_flit (requester i at [i*FLIT_W +: FLIT_W]).
// master: the packetizers driving flits; slave: the arbiter accepting them.
interface ni_inject_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int FLIT_W  = 32
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*FLIT_W-1:0] req_flit;
    logic [NUM_REQ-1:0]        req_last;
    logic [NUM_REQ-1:0]        req_ready;

    modport master (
        output req_valid,
        output req_flit,
        output req_last,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_flit,
        input  req_last,
        output req_ready
    );
endinterface

// File: rtl/ni_inject_arbiter_rr.sv
// Combinational rotating-priority picker.
// Ports: req (request vector), ptr (highest-priority index),
//        winner (first set request at or after ptr, cyclic), found.
module ni_rr_arbiter #(
    parameter int NUM_REQ = 4,
    localparam int IW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [IW-1:0]      winner,
    output logic               found
);

    always_comb begin
        int idx;
        idx    = 0;
        winner = '0;
        found  = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/ni_inject_arbiter.sv
// NI injection-port arbiter: grants one requester per packet (round robin),
// holds the grant until the tail flit leaves, muxes the owner's flits onto
// the router link and tracks router buffer credits.
// Ports: clk, rst (sync, active high), req (requester bundle, slave side),
//        out_valid/out_flit/out_last (link to router), credit_in (slot freed),
//        grant_id/busy (current owner), cred_err (sticky credit overflow).
module ni_inject_arbiter
    import ni_pkg::*;
#(
    parameter int  NUM_REQ = 4,
    parameter int  FLIT_W  = NI_FLIT_W,
    parameter int  CREDITS = 4,
    localparam int IW      = $clog2(NUM_REQ),
    localparam int CW      = $clog2(CREDITS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    ni_inject_arbiter_if.slave req,
    output logic              out_valid,
    output logic [FLIT_W-1:0] out_flit,
    output logic              out_last,
    input  logic              credit_in,
    output logic [IW-1:0]     grant_id,
    output logic              busy,
    output logic              cred_err
);

    ni_arb_state_t state, state_nxt;
    logic [IW-1:0] rr_ptr;
    logic [CW-1:0] credit_cnt;
    logic [IW-1:0] winner;
    logic          found;
    logic          has_credit;
    logic          send;

    ni_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req    (req.req_valid),
        .ptr    (rr_ptr),
        .winner (winner),
        .found  (found)
    );

    assign busy       = (state == NI_ARB_BUSY);
    assign has_credit = (credit_cnt != '0);

    always_comb begin
        state_nxt     = state;
        send          = 1'b0;
        req.req_ready = '0;
        out_valid     = 1'b0;
        out_flit      = '0;
        out_last      = 1'b0;
        case (state)
            NI_ARB_IDLE: begin
                if (found) state_nxt = NI_ARB_BUSY;
            end
            NI_ARB_BUSY: begin
                send                    = req.req_valid[grant_id] && has_credit;
                req.req_ready[grant_id] = has_credit;
                out_valid               = send;
                if (send) begin
                    out_flit = req.req_flit[grant_id*FLIT_W +: FLIT_W];
                    out_last = req.req_last[grant_id];
                    if (req.req_last[grant_id]) state_nxt = NI_ARB_IDLE;
                end
            end
            default: state_nxt = NI_ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= NI_ARB_IDLE;
            rr_ptr   <= '0;
            grant_id <= '0;
        end else begin
            state <= state_nxt;
            if (state == NI_ARB_IDLE && found) grant_id <= winner;
            if (send && req.req_last[grant_id]) begin
                if (grant_id == IW'(NUM_REQ - 1)) rr_ptr <= '0;
                else                              rr_ptr <= grant_id + IW'(1);
            end
        end
    end

    // send already implies a non-zero count, so the decrement cannot wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            credit_cnt <= CW'(CREDITS);
            cred_err   <= 1'b0;
        end else begin
            case ({send, credit_in})
                2'b10: credit_cnt <= credit_cnt - CW'(1);
                2'b01: begin
                    if (credit_cnt == CW'(CREDITS)) cred_err   <= 1'b1;
                    else                            credit_cnt <= credit_cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule
